conv3_row_sequencer: RTL and testbench
======================================

# conv3_row_sequencer

Upstream sequencer for the conv3 line-reuse buffers. It accepts a raster stream of 24-bit pixel words (3 × 8-bit channels) for one tile of `cfg_rows` × `cfg_cols`. It counts columns and rows, and drives the write/handshake and row-status controls that feed the pair of ping-pong reuse-buffer controllers (instances with r_flag 0 and 1). It also applies downstream backpressure and flags tile completion.

## Interface
- `DATA_W`, 24, pixel word width
- `COL_W`, 11, column counter width; matches the reuse-buffer address width
- `ROW_W`, 10, row counter width
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; latches the config and begins a tile (honoured only in IDLE)
- `cfg_cols`  in  COL_W  pixels per row; legal range 1..2047
- `cfg_rows`  in  ROW_W  rows per tile; legal range 3..1023
- `s_valid`  in  1  input pixel valid
- `s_data`  in  DATA_W  input pixel
- `s_ready`  out  1  input ready
- `m_ready`  in  1  downstream (conv3 PE) can absorb one pixel
- `buf_din`  out  DATA_W  registered pixel to the reuse buffers
- `bram_hs`  out  1  registered per-pixel strobe to the reuse buffers
- `read_flag`  out  1  ping-pong select; toggles once per completed row
- `conv3_reuse`  out  1  current pixel belongs to row index ≥ 2 (buffered rows are reused)
- `conv3_rowlast`  out  1  current pixel belongs to the final row of the tile
- `temp_hs`  out  1  `bram_hs & conv3_reuse`, delayed one cycle (aligns with BRAM read latency)
- `buf_conv3_rowlast`  out  1  `conv3_rowlast` delayed one cycle
- `busy`  out  1  high from the cycle after start is accepted until tile_done
- `tile_done`  out  1  one-cycle completion pulse
- `cfg_err`  out  1  one-cycle pulse when start carries an illegal config

## Operation
- FSM states: IDLE, FILL (rows 0–1), STREAM (rows 2..rows-2), LAST (row rows-1), DONE.
- IDLE → FILL on `start` with a legal config. The block latches `cfg_cols` and `cfg_rows`, and clears `col_cnt`, `row_cnt` and `read_flag`.
- IDLE with `start` and an illegal config (`cfg_cols`=0, or `cfg_rows`<3):
  - stay in IDLE;
  - `cfg_err`=1 for one cycle.
- `start` outside IDLE is ignored and has no side effects.
- Input handshake: `hs = s_valid & s_ready`.
  - `s_ready = busy_state & m_ready` (combinational), where busy_state = FILL, STREAM or LAST.
- On each `hs`:
  - `buf_din` ← `s_data`;
  - `bram_hs` ← 1;
  - `conv3_reuse` ← (`row_cnt` ≥ 2);
  - `conv3_rowlast` ← (`row_cnt` == rows-1);
  - `col_cnt` increments.
- With no `hs`, `bram_hs` ← 0. `buf_din`, `conv3_reuse` and `conv3_rowlast` hold their values.
- Row end is an `hs` with `col_cnt` == cols-1. At row end:
  - `col_cnt` ← 0;
  - `row_cnt` increments;
  - `row_end_d` ← 1;
  - state advances: FILL→STREAM after row 1; STREAM→LAST when the new row == rows-1; when rows==3, FILL goes directly to LAST after row 1.
- `read_flag` toggles on the edge after `row_end_d`, i.e. one cycle after the `bram_hs` of the row's last pixel.
- On the row end of the final row, LAST → DONE.
  - DONE lasts one cycle. `tile_done`=1, `read_flag` performs its final toggle, then → IDLE.
- `cols`=1: every `hs` is a row end, so `read_flag` toggles on every pixel with a one-cycle lag.
- Counter widths: `col_cnt` is COL_W wide and `row_cnt` is ROW_W wide. Neither wraps, because the config ranges bound them.

## Timing
- Reset (async assert, synchronous release):
  - state IDLE;
  - `col_cnt`, `row_cnt` and the latched config = 0;
  - all outputs 0, including `read_flag`, `buf_din`, `s_ready` and `busy`.
- Reset asserted mid-tile aborts the tile immediately. No `tile_done` is produced, and the next tile requires a new `start`.
- Latency:
  - `hs` at edge N → `bram_hs`/`buf_din` valid in cycle N+1;
  - `temp_hs` and `buf_conv3_rowlast` valid in cycle N+2;
  - `read_flag` toggle at edge N+2 for a last-column `hs` at N.
- `tile_done` is high in the cycle after the final `bram_hs`. `busy` falls in the same cycle.
- Backpressure: `m_ready`=0 forces `s_ready`=0. This creates bubbles (`bram_hs`=0); counters and the FSM hold.
- Throughput is one pixel per cycle under continuous valid/ready.
- Tile cycle count with no stalls: rows·cols + 2 from `start` to `tile_done`.

## Test plan
- **Basic 3×4 tile, continuous valid, `m_ready`=1:**
  - 12 `bram_hs` pulses; `read_flag` sequence 0,1,0,1;
  - `conv3_reuse`=1 only on pixels 8–11; `conv3_rowlast`=1 on pixels 8–11;
  - `tile_done` at cycle 14 after `start`.
- **5×2 tile with `m_ready` toggled every other cycle:**
  - `s_ready` follows `m_ready`; 10 `bram_hs` total;
  - `read_flag` toggles 5 times; no duplicated or lost `buf_din` values (data = incrementing counter).
- **`cfg_cols`=1, `cfg_rows`=3:**
  - `read_flag` toggles after every pixel;
  - `temp_hs` fires only for pixel 2, two cycles after its `hs`.
- **Illegal `start` (`cfg_rows`=2, then `cfg_cols`=0):**
  - `cfg_err` pulses twice; `busy` stays 0; `s_ready` stays 0.
- **`rst` asserted at pixel 6 of a 4×4 tile:**
  - all outputs go to 0 asynchronously; no `tile_done`;
  - a following legal `start` runs a full tile correctly from `read_flag`=0.
- **`start` pulsed during STREAM:** ignored; the tile completes with the originally latched dimensions.

Source files
------------

// File: rtl/conv3_row_sequencer.sv
// conv3_row_sequencer
// Raster sequencer in front of the ping-pong conv3 line-reuse buffers.
// Counts columns/rows of one tile, forwards each accepted pixel with a
// write strobe, tags pixels as reused-row / last-row, toggles the
// ping-pong select once per completed row and flags tile completion.
module conv3_row_sequencer #(
    parameter int DATA_W = 24,
    parameter int COL_W  = 11,
    parameter int ROW_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COL_W-1:0]  cfg_cols,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              m_ready,
    output logic [DATA_W-1:0] buf_din,
    output logic              bram_hs,
    output logic              read_flag,
    output logic              conv3_reuse,
    output logic              conv3_rowlast,
    output logic              temp_hs,
    output logic              buf_conv3_rowlast,
    output logic              busy,
    output logic              tile_done,
    output logic              cfg_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_LAST,
        ST_DONE
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col_cnt;
    logic [COL_W-1:0]  cols_q;
    logic [ROW_W-1:0]  row_cnt;
    logic [ROW_W-1:0]  rows_q;
    logic              row_end_d;

    logic              busy_state;
    logic              hs;
    logic              col_last;
    logic              cfg_ok;

    // Input handshake, end-of-row detect and config legality check
    always_comb begin
        busy_state = (state == ST_FILL) || (state == ST_STREAM) || (state == ST_LAST);
        s_ready    = busy_state & m_ready;
        hs         = s_valid & s_ready;
        col_last   = (col_cnt == cols_q - COL_W'(1));
        cfg_ok     = (cfg_cols != '0) && (cfg_rows >= ROW_W'(3));
    end

    // Tile FSM with counters, pixel forwarding and all registered controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            col_cnt           <= '0;
            row_cnt           <= '0;
            cols_q            <= '0;
            rows_q            <= '0;
            row_end_d         <= 1'b0;
            buf_din           <= '0;
            bram_hs           <= 1'b0;
            read_flag         <= 1'b0;
            conv3_reuse       <= 1'b0;
            conv3_rowlast     <= 1'b0;
            temp_hs           <= 1'b0;
            buf_conv3_rowlast <= 1'b0;
            busy              <= 1'b0;
            tile_done         <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            tile_done         <= 1'b0;
            cfg_err           <= 1'b0;
            row_end_d         <= 1'b0;
            bram_hs           <= hs;
            temp_hs           <= bram_hs & conv3_reuse;
            buf_conv3_rowlast <= conv3_rowlast;

            // Ping-pong select flips one cycle after the row's last strobe
            if (row_end_d) begin
                read_flag <= ~read_flag;
            end

            if (hs) begin
                buf_din       <= s_data;
                conv3_reuse   <= (row_cnt >= ROW_W'(2));
                conv3_rowlast <= (row_cnt == rows_q - ROW_W'(1));
                if (col_last) begin
                    col_cnt   <= '0;
                    row_cnt   <= row_cnt + ROW_W'(1);
                    row_end_d <= 1'b1;
                end else begin
                    col_cnt   <= col_cnt + COL_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state     <= ST_FILL;
                            cols_q    <= cfg_cols;
                            rows_q    <= cfg_rows;
                            col_cnt   <= '0;
                            row_cnt   <= '0;
                            read_flag <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            cfg_err   <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    // A 3-row tile has no middle rows, so skip STREAM
                    if (hs && col_last && (row_cnt == ROW_W'(1))) begin
                        state <= (rows_q == ROW_W'(3)) ? ST_LAST : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (hs && col_last && (row_cnt + ROW_W'(1) == rows_q - ROW_W'(1))) begin
                        state <= ST_LAST;
                    end
                end
                ST_LAST: begin
                    if (hs && col_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    tile_done <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3_row_sequencer.sv
// Self-checking bench for conv3_row_sequencer: a pixel-index model predicts
// every output each cycle; directed tiles add literal expectations.
`timescale 1ns/1ps
module tb_conv3_row_sequencer;

    localparam int DATA_W = 24;
    localparam int COL_W  = 11;
    localparam int ROW_W  = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [COL_W-1:0]  cfg_cols = '0;
    logic [ROW_W-1:0]  cfg_rows = '0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] buf_din;
    logic              bram_hs;
    logic              read_flag;
    logic              conv3_reuse;
    logic              conv3_rowlast;
    logic              temp_hs;
    logic              buf_conv3_rowlast;
    logic              busy;
    logic              tile_done;
    logic              cfg_err;

    conv3_row_sequencer #(
        .DATA_W (DATA_W),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_cols          (cfg_cols),
        .cfg_rows          (cfg_rows),
        .s_valid           (s_valid),
        .s_data            (s_data),
        .s_ready           (s_ready),
        .m_ready           (m_ready),
        .buf_din           (buf_din),
        .bram_hs           (bram_hs),
        .read_flag         (read_flag),
        .conv3_reuse       (conv3_reuse),
        .conv3_rowlast     (conv3_rowlast),
        .temp_hs           (temp_hs),
        .buf_conv3_rowlast (buf_conv3_rowlast),
        .busy              (busy),
        .tile_done         (tile_done),
        .cfg_err           (cfg_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                m_busy, m_accept, m_fin, m_tg;
    int                m_cols, m_rows, m_pix;
    bit                hs_m, idle_m;
    int                row_m, col_m;
    logic              e_bram_hs, e_reuse, e_rowlast, e_temp_hs, e_buf_rowlast;
    logic              e_read_flag, e_busy, e_tile_done, e_cfg_err;
    logic [DATA_W-1:0] e_buf_din;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_accept = 0; m_fin = 0; m_tg = 0;
            m_cols = 0; m_rows = 0; m_pix = 0;
            e_bram_hs = 0; e_reuse = 0; e_rowlast = 0; e_temp_hs = 0;
            e_buf_rowlast = 0; e_read_flag = 0; e_busy = 0; e_tile_done = 0;
            e_cfg_err = 0; e_buf_din = '0;
        end else begin
            cyc++;
            idle_m = !m_busy;
            hs_m = m_accept && s_valid && m_ready;
            e_temp_hs = e_bram_hs && e_reuse;
            e_buf_rowlast = e_rowlast;
            e_cfg_err = 0;
            e_tile_done = 0;
            if (m_tg) e_read_flag = !e_read_flag;
            m_tg = 0;
            if (m_fin) begin
                e_tile_done = 1; e_busy = 0; m_busy = 0; m_fin = 0;
            end
            e_bram_hs = hs_m;
            if (hs_m) begin
                row_m = m_pix / m_cols;
                col_m = m_pix % m_cols;
                e_buf_din = s_data;
                e_reuse = (row_m >= 2);
                e_rowlast = (row_m == m_rows - 1);
                if (col_m == m_cols - 1) m_tg = 1;
                if (m_pix == m_rows * m_cols - 1) begin
                    m_accept = 0; m_fin = 1;
                end
                m_pix++;
            end
            if (start && idle_m) begin
                if (cfg_cols == 0 || cfg_rows < 3) begin
                    e_cfg_err = 1;
                end else begin
                    m_busy = 1; m_accept = 1; e_busy = 1;
                    m_cols = int'(cfg_cols); m_rows = int'(cfg_rows);
                    m_pix = 0; e_read_flag = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare + event counters ----------------
    int   n_bram, n_reuse, n_rowlast, n_temp, n_err, n_done, n_tog;
    int   done_cyc, temp_cyc, st_cyc;
    logic prev_busy = 0, prev_rf = 0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("s_ready", s_ready, m_accept && m_ready);
            chk("bram_hs", bram_hs, e_bram_hs);
            chk("buf_din", buf_din, e_buf_din);
            chk("read_flag", read_flag, e_read_flag);
            chk("conv3_reuse", conv3_reuse, e_reuse);
            chk("conv3_rowlast", conv3_rowlast, e_rowlast);
            chk("temp_hs", temp_hs, e_temp_hs);
            chk("buf_conv3_rowlast", buf_conv3_rowlast, e_buf_rowlast);
            chk("busy", busy, e_busy);
            chk("tile_done", tile_done, e_tile_done);
            chk("cfg_err", cfg_err, e_cfg_err);
            if (bram_hs) n_bram++;
            if (bram_hs && conv3_reuse) n_reuse++;
            if (bram_hs && conv3_rowlast) n_rowlast++;
            if (temp_hs) begin n_temp++; temp_cyc = cyc; end
            if (cfg_err) n_err++;
            if (tile_done) begin n_done++; done_cyc = cyc; end
            if (prev_busy && (read_flag !== prev_rf)) n_tog++;
            prev_busy = busy;
            prev_rf = read_flag;
        end else begin
            prev_busy = 0;
            prev_rf = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    int src = 0;

    task automatic clear_counts();
        n_bram = 0; n_reuse = 0; n_rowlast = 0; n_temp = 0;
        n_err = 0; n_done = 0; n_tog = 0; done_cyc = 0; temp_cyc = 0;
    endtask

    // Called and returns at a falling edge
    task automatic do_start(input int rows, input int cols);
        cfg_rows = ROW_W'(rows);
        cfg_cols = COL_W'(cols);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        st_cyc = cyc;
    endtask

    task automatic stream(input int n, input int mode);
        int sent = 0;
        int c = 0;
        while (sent < n && c < 400) begin
            s_valid = 1'b1;
            s_data = DATA_W'(src);
            m_ready = (mode == 1) ? (c % 2 == 0) : 1'b1;
            #3;
            if (s_ready) begin
                sent++;
                src++;
            end
            @(negedge clk);
            c++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (sent < n) begin
            errors++;
            $display("FAIL stream_timeout: got %0d pixels expected %0d", sent, n);
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL tile_done_timeout: got none within %0d cycles expected 1", budget);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_bram_hs"}, bram_hs, 0);
        chk({tag, "_buf_din"}, buf_din, 0);
        chk({tag, "_read_flag"}, read_flag, 0);
        chk({tag, "_reuse"}, conv3_reuse, 0);
        chk({tag, "_rowlast"}, conv3_rowlast, 0);
        chk({tag, "_temp_hs"}, temp_hs, 0);
        chk({tag, "_buf_rowlast"}, buf_conv3_rowlast, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tile_done"}, tile_done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counts();
        // reset state
        #1;
        chk_all_zero("reset");
        idle(2);
        rst = 1'b0;
        idle(2);

        // 3x4 tile, continuous
        clear_counts();
        do_start(3, 4);
        stream(12, 0);
        wait_done(20);
        idle(2);
        chk("t1_bram_count", n_bram, 12);
        chk("t1_reuse_count", n_reuse, 4);
        chk("t1_rowlast_count", n_rowlast, 4);
        chk("t1_rf_toggles", n_tog, 3);
        chk("t1_rf_end", read_flag, 1);
        chk("t1_done_latency", done_cyc - st_cyc, 13);
        chk("t1_done_count", n_done, 1);

        // 5x2 tile, m_ready alternating
        clear_counts();
        do_start(5, 2);
        stream(10, 1);
        wait_done(40);
        idle(2);
        chk("t2_bram_count", n_bram, 10);
        chk("t2_rf_toggles", n_tog, 5);
        chk("t2_last_din", buf_din, DATA_W'(src - 1));

        // single-column 3-row tile
        clear_counts();
        do_start(3, 1);
        stream(3, 0);
        wait_done(20);
        idle(2);
        chk("t3_rf_toggles", n_tog, 3);
        chk("t3_temp_count", n_temp, 1);
        chk("t3_temp_latency", temp_cyc - st_cyc, 4);
        chk("t3_done_latency", done_cyc - st_cyc, 4);

        // illegal configs
        clear_counts();
        do_start(2, 4);
        idle(2);
        do_start(5, 0);
        idle(3);
        chk("t4_cfg_err_count", n_err, 2);
        chk("t4_busy", busy, 0);
        chk("t4_s_ready", s_ready, 0);
        chk("t4_done_count", n_done, 0);

        // reset in the middle of a 4x4 tile
        clear_counts();
        do_start(4, 4);
        stream(6, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("t5_no_done", n_done, 0);
        clear_counts();
        do_start(4, 4);
        stream(16, 0);
        wait_done(30);
        idle(2);
        chk("t5_bram_count", n_bram, 16);
        chk("t5_rf_toggles", n_tog, 4);
        chk("t5_rf_end", read_flag, 0);
        chk("t5_done_latency", done_cyc - st_cyc, 17);

        // start pulsed during STREAM is ignored
        clear_counts();
        do_start(5, 3);
        stream(8, 0);
        do_start(2, 0);
        stream(7, 0);
        wait_done(30);
        idle(2);
        chk("t6_bram_count", n_bram, 15);
        chk("t6_rf_toggles", n_tog, 5);
        chk("t6_done_count", n_done, 1);
        chk("t6_no_cfg_err", n_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
